// File: rtl/alu_flag_register.sv
// Registered ALU status stage: 2-entry result/flag queue, condition codes, branch condition and overflow tracking.
// Optional macro FLAG_CHECK_EN adds a sticky check of in_zero/in_negative against in_result.
module alu_flag_register #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_negative,
  input  logic              in_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_negative,
  output logic              out_overflow,
  input  logic [2:0]        cond_sel,
  output logic              cond_true,
  input  logic              clr_sticky,
  output logic              sticky_ovf,
  output logic [CNT_W-1:0]  ovf_count,
  output logic              flag_mismatch
);

  // state | meaning
  // EMPTY | no entries held
  // ONE   | head holds the only entry
  // FULL  | head holds oldest, tail holds newest
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam int ENT_W = DATA_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [ENT_W-1:0] head, tail, in_entry;
  logic             push, pop;
  logic             load_head_in, load_head_tail, load_tail;
  logic             cc_zero, cc_negative, cc_overflow;
  logic             push_ovf;

  assign in_entry = {in_result, in_zero, in_negative, in_overflow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // in_ready is gated by rst_n so it reads 0 while reset is held.
  always_comb begin
    state_nxt      = state;
    in_ready       = rst_n && (state != FULL);
    out_valid      = (state != EMPTY);
    push           = in_valid && in_ready;
    pop            = out_valid && out_ready;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt    = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            state_nxt = FULL;
            load_tail = 1'b1;
          end
          2'b01: state_nxt = EMPTY;
          2'b11: load_head_in = 1'b1;
          default: state_nxt = ONE;
        endcase
      end
      FULL: begin
        if (pop) begin
          state_nxt      = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head_in)        head <= in_entry;
      else if (load_head_tail) head <= tail;
      if (load_tail)           tail <= in_entry;
    end
  end

  assign {out_result, out_zero, out_negative, out_overflow} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zero     <= 1'b0;
      cc_negative <= 1'b0;
      cc_overflow <= 1'b0;
    end else if (push) begin
      cc_zero     <= in_zero;
      cc_negative <= in_negative;
      cc_overflow <= in_overflow;
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      3'd0: cond_true = cc_zero;
      3'd1: cond_true = !cc_zero;
      3'd2: cond_true = cc_negative;
      3'd3: cond_true = !cc_negative;
      3'd4: cond_true = cc_overflow;
      3'd5: cond_true = !cc_overflow;
      3'd6: cond_true = (cc_negative == cc_overflow);
      3'd7: cond_true = (cc_negative != cc_overflow);
      default: cond_true = 1'b0;
    endcase
  end

  assign push_ovf = push && in_overflow;

  // A clear coinciding with an overflow push restarts tracking from that push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= '0;
    end else if (clr_sticky) begin
      sticky_ovf <= push_ovf;
      ovf_count  <= push_ovf ? CNT_ONE : '0;
    end else if (push_ovf) begin
      sticky_ovf <= 1'b1;
      if (ovf_count != CNT_MAX) ovf_count <= ovf_count + CNT_ONE;
    end
  end

`ifdef FLAG_CHECK_EN
  logic calc_zero, calc_negative, push_mismatch;

  assign calc_zero     = (in_result == '0);
  assign calc_negative = in_result[DATA_W-1];
  assign push_mismatch = push && ((calc_zero != in_zero) || (calc_negative != in_negative));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          flag_mismatch <= 1'b0;
    else if (clr_sticky) flag_mismatch <= push_mismatch;
    else if (push_mismatch) flag_mismatch <= 1'b1;
  end
`else
  assign flag_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_flag_register.sv
// Bench for alu_flag_register: queue-based reference model checked every cycle plus directed literal checks.
module tb_alu_flag_register;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;
  localparam int MAXC   = 3;
`ifdef FLAG_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_result = '0;
  logic              in_zero = 1'b0;
  logic              in_negative = 1'b0;
  logic              in_overflow = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_result;
  logic              out_zero, out_negative, out_overflow;
  logic [2:0]        cond_sel = 3'd0;
  logic              cond_true;
  logic              clr_sticky = 1'b0;
  logic              sticky_ovf;
  logic [CNT_W-1:0]  ovf_count;
  logic              flag_mismatch;

  int checks = 0;
  int errors = 0;

  alu_flag_register #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_negative(in_negative), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_negative(out_negative), .out_overflow(out_overflow),
    .cond_sel(cond_sel), .cond_true(cond_true),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count),
    .flag_mismatch(flag_mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct {
    logic [DATA_W-1:0] r;
    logic z, n, v;
  } ent_t;

  ent_t mq[$];
  logic m_z, m_n, m_v;
  logic m_sticky, m_mis;
  int   m_count;
  logic [DATA_W-1:0] emitted[$];

  function automatic logic cond_of(input logic [2:0] sel, input logic z, input logic n, input logic v);
    case (sel)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return n;
      3'd3: return !n;
      3'd4: return v;
      3'd5: return !v;
      3'd6: return n == v;
      default: return n != v;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      {m_z, m_n, m_v} = 3'b000;
      m_sticky = 1'b0;
      m_mis    = 1'b0;
      m_count  = 0;
    end else begin
      automatic logic push = in_valid && (mq.size() < 2);
      automatic logic pop  = (mq.size() > 0) && out_ready;
      automatic logic povf = push && in_overflow;
      automatic logic pmis = CHK && push &&
                             (((in_result == 0) != in_zero) || (in_result[DATA_W-1] != in_negative));
      automatic ent_t e;
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.r = in_result; e.z = in_zero; e.n = in_negative; e.v = in_overflow;
        mq.push_back(e);
        {m_z, m_n, m_v} = {in_zero, in_negative, in_overflow};
      end
      if (clr_sticky) begin
        m_sticky = povf;
        m_count  = povf ? 1 : 0;
        m_mis    = pmis;
      end else begin
        if (povf) begin
          m_sticky = 1'b1;
          if (m_count < MAXC) m_count++;
        end
        if (pmis) m_mis = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_ovf_count", ovf_count, 0);
      chk("rst_sticky", sticky_ovf, 0);
      chk("rst_mismatch", flag_mismatch, 0);
    end else begin
      chk("out_valid", out_valid, mq.size() != 0);
      chk("in_ready", in_ready, mq.size() < 2);
      if (mq.size() != 0) begin
        chk("out_result", out_result, mq[0].r);
        chk("out_flags", {out_zero, out_negative, out_overflow}, {mq[0].z, mq[0].n, mq[0].v});
      end
      chk("cond_true", cond_true, cond_of(cond_sel, m_z, m_n, m_v));
      chk("sticky_ovf", sticky_ovf, m_sticky);
      chk("ovf_count", ovf_count, m_count);
      chk("flag_mismatch", flag_mismatch, m_mis);
      if (out_valid && out_ready) emitted.push_back(out_result);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Holds the entry until accepted; returns 1 time unit after the accepting edge.
  task automatic push_raw(input logic [DATA_W-1:0] r, input logic z, input logic n, input logic v);
    automatic bit ok = 1'b0;
    in_valid = 1'b1; in_result = r; in_zero = z; in_negative = n; in_overflow = v;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("push_timeout", 1, 0);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic do_push(input logic [DATA_W-1:0] r, input logic v);
    push_raw(r, r == 0, r[DATA_W-1], v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and release
    repeat (3) @(posedge clk);
    #1;
    chk("init_out_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    cycle();

    // Throughput
    out_ready = 1'b1;
    do_push(32'h0000_0005, 1'b0);
    do_push(32'h8000_0000, 1'b0);
    cond_sel = 3'd2;
    #1 chk("mi_after_2nd", cond_true, 1);
    do_push(32'h0000_0000, 1'b0);
    repeat (3) cycle();
    chk("tp_count", emitted.size(), 3);
    if (emitted.size() == 3) begin
      chk("tp_0", emitted[0], 32'h0000_0005);
      chk("tp_1", emitted[1], 32'h8000_0000);
      chk("tp_2", emitted[2], 32'h0000_0000);
    end
    emitted.delete();

    // Backpressure
    out_ready = 1'b0;
    do_push(32'h0000_0011, 1'b0);
    do_push(32'h0000_0022, 1'b0);
    fork
      do_push(32'h0000_0033, 1'b0);
      begin
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_head", out_result, 32'h0000_0011);
        repeat (2) @(negedge clk);
        chk("bp_head_hold", out_result, 32'h0000_0011);
        cycle();
        out_ready = 1'b1;
      end
    join
    repeat (4) cycle();
    chk("bp_count", emitted.size(), 3);
    if (emitted.size() == 3) begin
      chk("bp_0", emitted[0], 32'h0000_0011);
      chk("bp_1", emitted[1], 32'h0000_0022);
      chk("bp_2", emitted[2], 32'h0000_0033);
    end

    // Condition codes
    do_push(32'h8000_0001, 1'b0);
    cond_sel = 3'd6; #1 chk("ge_n1v0", cond_true, 0);
    cond_sel = 3'd7; #1 chk("lt_n1v0", cond_true, 1);
    do_push(32'h8000_0002, 1'b1);
    cond_sel = 3'd6; #1 chk("ge_n1v1", cond_true, 1);
    do_push(32'h0000_0000, 1'b0);
    cond_sel = 3'd0; #1 chk("eq_z1", cond_true, 1);
    cond_sel = 3'd1; #1 chk("ne_z1", cond_true, 0);

    // Overflow tracking and saturation
    cycle();
    clr_sticky = 1'b1;
    cycle();
    clr_sticky = 1'b0;
    chk("clr_count", ovf_count, 0);
    chk("clr_sticky", sticky_ovf, 0);
    for (int i = 1; i <= 5; i++) do_push(DATA_W'(i), 1'b1);
    chk("sat_count", ovf_count, 3);
    chk("sat_sticky", sticky_ovf, 1);
    clr_sticky = 1'b1;
    do_push(32'h0000_0007, 1'b1);
    clr_sticky = 1'b0;
    chk("clr_push_count", ovf_count, 1);
    chk("clr_push_sticky", sticky_ovf, 1);

    // Flag self-check
    clr_sticky = 1'b1;
    cycle();
    clr_sticky = 1'b0;
    push_raw(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    chk("mismatch_set", flag_mismatch, CHK);
    do_push(32'h0000_0009, 1'b0);
    repeat (3) cycle();
    chk("mismatch_hold", flag_mismatch, CHK);

    // Reset with two entries queued
    out_ready = 1'b0;
    do_push(32'h0000_00a1, 1'b1);
    do_push(32'h0000_00a2, 1'b1);
    chk("pre_rst_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_count", ovf_count, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    emitted.delete();
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    repeat (4) cycle();
    chk("post_rst_emitted", emitted.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
